core_ctrl_fsm: RTL and testbench

Multi-cycle sequencing controller for the RV32 core (PC, IFU, IDU, register file, EXU). It replaces the free-running `pc + 4` / always-enabled update with an explicit FSM: fetch over a valid/ready instruction port, one decode cycle, one execute cycle, an optional data-memory phase, and write-back. In write-back it issues `pc_wen` and the qualified `reg_wen`. It also maintains halt status and cycle/instret counters for the simulation harness.

---
 rtl/core_ctrl_pkg.sv | 26 ++
 rtl/bus_wait_timer.sv | 34 +++
 rtl/core_ctrl_fsm.sv | 140 ++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the RV32 core sequencing controller.
package core_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_FWAIT  = 4'd2,
      ST_DECODE = 4'd3,
      ST_EXEC   = 4'd4,
      ST_MEM    = 4'd5,
      ST_MWAIT  = 4'd6,
      ST_WB     = 4'd7,
      ST_HALT   = 4'd8
   } ctrl_state_e;

   typedef enum logic [1:0] {
      HC_NONE    = 2'b00,
      HC_EBREAK  = 2'b01,
      HC_ILLEGAL = 2'b10,
      HC_BUS     = 2'b11
   } halt_code_e;

   localparam int DEFAULT_TIMEOUT = 255;
   localparam int TIMER_W         = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// Cycle counter for one bus phase (fetch or data memory); flags when the phase
// has used up its TIMEOUT cycle budget.
module bus_wait_timer
   import core_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // cnt holds the number of cycles already spent before the current one, so
   // the TIMEOUT-th cycle of the phase sees cnt == TIMEOUT-1.
   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {TIMER_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Stays asserted in FWAIT/MWAIT once the request phase used the budget.
   assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencing controller: fetch, decode, execute, optional memory
// phase, write-back; plus sticky halt status and cycle/instret counters.
module core_ctrl_fsm
   import core_ctrl_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   input  logic             ifu_rsp_valid,
   input  logic             ifu_rsp_err,
   output logic             inst_en,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_ebreak,
   input  logic             dec_illegal,
   input  logic             dec_regen,
   output logic             lsu_req_valid,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   input  logic             lsu_rsp_err,
   output logic             pc_wen,
   output logic             reg_wen,
   output logic             halt,
   output logic [1:0]       halt_code,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [3:0] S_IDLE   = ST_IDLE;
   localparam logic [3:0] S_FETCH  = ST_FETCH;
   localparam logic [3:0] S_FWAIT  = ST_FWAIT;
   localparam logic [3:0] S_DECODE = ST_DECODE;
   localparam logic [3:0] S_EXEC   = ST_EXEC;
   localparam logic [3:0] S_MEM    = ST_MEM;
   localparam logic [3:0] S_MWAIT  = ST_MWAIT;
   localparam logic [3:0] S_WB     = ST_WB;
   localparam logic [3:0] S_HALT   = ST_HALT;

   logic [3:0]       state_q, state_d;
   logic [1:0]       code_q, code_d;
   logic             instret_inc;
   logic             bus_phase;
   logic             counting;
   logic             expired;
   logic [CNT_W-1:0] cycle_q, instret_q;

   assign bus_phase = (state_q == S_FETCH) || (state_q == S_FWAIT) ||
                      (state_q == S_MEM)   || (state_q == S_MWAIT);
   assign counting  = (state_q != S_IDLE) && (state_q != S_HALT);

   // Cleared in every non-bus state, so it restarts on entering FETCH or MEM.
   bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!bus_phase),
      .en      (bus_phase),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      instret_inc = 1'b0;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (ifu_req_ready) state_d = S_FWAIT;
            else if (expired) begin state_d = S_HALT; code_d = HC_BUS; end
         end
         S_FWAIT: begin
            if (ifu_rsp_valid) begin
               if (ifu_rsp_err) begin state_d = S_HALT; code_d = HC_BUS; end
               else state_d = S_DECODE;
            end else if (expired) begin
               state_d = S_HALT; code_d = HC_BUS;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               state_d = S_HALT; code_d = HC_ILLEGAL;
            end else if (dec_ebreak) begin
               state_d = S_HALT; code_d = HC_EBREAK; instret_inc = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC:   state_d = (dec_load || dec_store) ? S_MEM : S_WB;
         S_MEM: begin
            if (lsu_req_ready) state_d = S_MWAIT;
            else if (expired) begin state_d = S_HALT; code_d = HC_BUS; end
         end
         S_MWAIT: begin
            if (lsu_rsp_valid) begin
               if (lsu_rsp_err) begin state_d = S_HALT; code_d = HC_BUS; end
               else state_d = S_WB;
            end else if (expired) begin
               state_d = S_HALT; code_d = HC_BUS;
            end
         end
         S_WB: begin
            instret_inc = 1'b1;
            state_d     = run ? S_FETCH : S_IDLE;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         code_q    <= HC_NONE;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         if (counting)    cycle_q   <= cycle_q + 1'b1;
         if (instret_inc) instret_q <= instret_q + 1'b1;
      end
   end

   assign ifu_req_valid = (state_q == S_FETCH);
   assign lsu_req_valid = (state_q == S_MEM);
   assign inst_en       = (state_q == S_FWAIT) && ifu_rsp_valid && !ifu_rsp_err;
   assign pc_wen        = (state_q == S_WB);
   assign reg_wen       = (state_q == S_WB) && dec_regen && !dec_store;
   assign halt          = (state_q == S_HALT);
   assign halt_code     = code_q;
   assign state         = state_q;
   assign cycle_cnt     = cycle_q;
   assign instret_cnt   = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Self-checking bench for core_ctrl_fsm: instruction vector table with a
// result scoreboard, plus directed timeout / run / reset sequences.
module tb_core_ctrl_fsm;

   localparam logic [3:0] T_IDLE   = 4'd0;
   localparam logic [3:0] T_FETCH  = 4'd1;
   localparam logic [3:0] T_FWAIT  = 4'd2;
   localparam logic [3:0] T_DECODE = 4'd3;
   localparam logic [3:0] T_MEM    = 4'd5;
   localparam logic [3:0] T_MWAIT  = 4'd6;
   localparam logic [3:0] T_WB     = 4'd7;
   localparam logic [3:0] T_HALT   = 4'd8;
   localparam int W = 39;

   logic clk, rst, run;
   logic ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic dec_load, dec_store, dec_ebreak, dec_illegal, dec_regen;
   logic lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;

   logic        ifu_req_valid, inst_en, lsu_req_valid, pc_wen, reg_wen, halt;
   logic [1:0]  halt_code;
   logic [3:0]  state;
   logic [63:0] cycle_cnt, instret_cnt;

   logic        to_ifu_req_valid, to_inst_en, to_lsu_req_valid, to_pc_wen, to_reg_wen, to_halt;
   logic [1:0]  to_halt_code;
   logic [3:0]  to_state;
   logic [63:0] to_cycle_cnt, to_instret_cnt;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      bit ld, st, eb, il, rg, ie, le;
      int dly;
      int lat, pcn, rgn, inn;
      logic [1:0] code;
      int inst;
   } vec_t;
   vec_t vecs[10];

   core_ctrl_fsm dut (
      .clk(clk), .rst(rst), .run(run),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .inst_en(inst_en),
      .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak),
      .dec_illegal(dec_illegal), .dec_regen(dec_regen),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
      .pc_wen(pc_wen), .reg_wen(reg_wen), .halt(halt), .halt_code(halt_code),
      .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   // Short-budget instance for the timeout sequences; shares all inputs.
   core_ctrl_fsm #(.CNT_W(64), .TIMEOUT(4)) u_to (
      .clk(clk), .rst(rst), .run(run),
      .ifu_req_valid(to_ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .inst_en(to_inst_en),
      .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak),
      .dec_illegal(dec_illegal), .dec_regen(dec_regen),
      .lsu_req_valid(to_lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
      .pc_wen(to_pc_wen), .reg_wen(to_reg_wen), .halt(to_halt), .halt_code(to_halt_code),
      .state(to_state), .cycle_cnt(to_cycle_cnt), .instret_cnt(to_instret_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      run = 0; ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
      dec_load = 0; dec_store = 0; dec_ebreak = 0; dec_illegal = 0; dec_regen = 0;
      lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   function automatic logic [W-1:0] pack_res(int lat, int pcn, int rgn, int inn, logic h,
                                            logic [1:0] code, logic [63:0] inst, logic [63:0] cyc);
      return {8'(lat), 4'(pcn), 4'(rgn), 4'(inn), h, code, inst[7:0], cyc[7:0]};
   endfunction

   // One instruction from IDLE with a reactive zero-wait IFU and an LSU whose
   // response comes v.dly cycles late; run drops once fetch starts.
   task automatic run_vec(input int idx, input vec_t v);
      int t = 0, mw = 0, pcn = 0, rgn = 0, inn = 0, done_t = 0;
      bit started = 0, done = 0;
      logic [W-1:0] exp, act;
      do_reset();
      dec_load = v.ld; dec_store = v.st; dec_ebreak = v.eb; dec_illegal = v.il; dec_regen = v.rg;
      exp_q.push_back(pack_res(v.lat, v.pcn, v.rgn, v.inn, (v.code != 2'b00), v.code,
                               64'(v.inst), 64'(v.lat)));
      run = 1;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         if (started) t++;
         else if (ifu_req_valid) begin started = 1; t = 1; run = 0; end
         ifu_req_ready = ifu_req_valid;
         ifu_rsp_valid = (state == T_FWAIT);
         ifu_rsp_err   = ifu_rsp_valid & v.ie;
         lsu_req_ready = lsu_req_valid;
         if (state == T_MWAIT) mw++; else mw = 0;
         lsu_rsp_valid = (mw > v.dly);
         lsu_rsp_err   = lsu_rsp_valid & v.le;
         #1;
         if (pc_wen) begin pcn++; done_t = t; end
         if (reg_wen) rgn++;
         if (inst_en) inn++;
         if (started && halt) begin done_t = t - 1; done = 1; end
         else if (started && state == T_IDLE) done = 1;
      end
      if (!done) check($sformatf("vec%0d_finished", idx), 64'd0, 64'd1);
      act = pack_res(done_t, pcn, rgn, inn, halt, halt_code, instret_cnt, cycle_cnt);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_result", idx), 64'(act), 64'(exp));
   endtask

   // ---------------- test ----------------
   initial begin
      int n;
      //          ld st eb il rg ie le dly lat pc rg in code inst
      vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 0,  5, 1, 1, 1, 2'd0, 1};
      vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 1, 2'd0, 1};
      vecs[2] = '{1, 0, 0, 0, 1, 0, 0, 0,  7, 1, 1, 1, 2'd0, 1};
      vecs[3] = '{1, 0, 0, 0, 1, 0, 0, 3, 10, 1, 1, 1, 2'd0, 1};
      vecs[4] = '{0, 1, 0, 0, 1, 0, 0, 0,  7, 1, 0, 1, 2'd0, 1};
      vecs[5] = '{0, 1, 0, 0, 0, 0, 0, 1,  8, 1, 0, 1, 2'd0, 1};
      vecs[6] = '{0, 0, 1, 0, 1, 0, 0, 0,  3, 0, 0, 1, 2'd1, 1};
      vecs[7] = '{0, 0, 1, 1, 1, 0, 0, 0,  3, 0, 0, 1, 2'd2, 0};
      vecs[8] = '{0, 0, 0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 2'd3, 0};
      vecs[9] = '{1, 0, 0, 0, 1, 0, 1, 0,  6, 0, 0, 1, 2'd3, 0};

      // Reset state
      do_reset();
      #1;
      check("rst_outputs", 64'({ifu_req_valid, inst_en, lsu_req_valid, pc_wen, reg_wen,
                                halt, halt_code, state}), 64'd0);
      check("rst_counters", cycle_cnt | instret_cnt, 64'd0);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // ebreak: halt is absorbing and cycle_cnt freezes
      run_vec(6, vecs[6]);
      repeat (5) @(negedge clk);
      #1;
      check("ebreak_cycle_frozen", cycle_cnt, 64'd3);
      check("ebreak_still_halted", 64'({halt, halt_code, state, pc_wen}), 64'({1'b1, 2'd1, T_HALT, 1'b0}));

      // Fetch timeout with TIMEOUT=4 and ready held low
      do_reset();
      run = 1; n = 0;
      for (int cyc = 0; cyc < 20 && !to_halt; cyc++) begin
         @(negedge clk); #1;
         if (to_ifu_req_valid) n++;
      end
      check("to_fetch_cycles", 64'(n), 64'd4);
      check("to_halt", 64'({to_halt, to_halt_code, to_state}), 64'({1'b1, 2'd3, T_HALT}));

      // Ready arriving in the 4th cycle wins over the timeout
      do_reset();
      run = 1; n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         ifu_req_ready = 0;
         if (to_ifu_req_valid) begin
            n++;
            if (n == 4) ifu_req_ready = 1;
         end else if (n > 0) break;
      end
      #1;
      check("to_ready_in_last", 64'({to_halt, to_state}), 64'({1'b0, T_FWAIT}));
      ifu_rsp_valid = 1;
      @(negedge clk);
      ifu_rsp_valid = 0;
      #1;
      check("to_rsp_after_budget", 64'({to_halt, to_state}), 64'({1'b0, T_DECODE}));

      // run dropped during MWAIT: instruction completes, then IDLE
      do_reset();
      dec_load = 1; dec_regen = 1; run = 1;
      for (int cyc = 0; cyc < 20 && state != T_MWAIT; cyc++) begin
         @(negedge clk);
         ifu_req_ready = ifu_req_valid;
         ifu_rsp_valid = (state == T_FWAIT);
         lsu_req_ready = lsu_req_valid;
      end
      ifu_rsp_valid = 0;
      check("mwait_reached", 64'(state), 64'(T_MWAIT));
      run = 0;
      repeat (2) @(negedge clk);
      lsu_rsp_valid = 1;
      @(negedge clk);
      lsu_rsp_valid = 0;
      #1;
      check("run_drop_wb", 64'({state, pc_wen, reg_wen}), 64'({T_WB, 1'b1, 1'b1}));
      @(negedge clk); #1;
      check("run_drop_idle", 64'({state, ifu_req_valid}), 64'({T_IDLE, 1'b0}));
      run = 1;
      @(negedge clk); #1;
      check("run_restart_fetch", 64'({state, ifu_req_valid}), 64'({T_FETCH, 1'b1}));

      // Asynchronous reset with a data request outstanding
      do_reset();
      dec_store = 1; run = 1;
      for (int cyc = 0; cyc < 20 && state != T_MEM; cyc++) begin
         @(negedge clk);
         ifu_req_ready = ifu_req_valid;
         ifu_rsp_valid = (state == T_FWAIT);
         lsu_req_ready = 0;
      end
      ifu_rsp_valid = 0;
      @(negedge clk); #1;
      check("mem_req_held", 64'({state, lsu_req_valid}), 64'({T_MEM, 1'b1}));
      #2 rst = 0;
      #1;
      check("async_rst_outputs", 64'({ifu_req_valid, inst_en, lsu_req_valid, pc_wen, reg_wen,
                                     halt, halt_code, state}), 64'd0);
      check("async_rst_counters", cycle_cnt | instret_cnt, 64'd0);
      rst = 1;

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
